vid_in_capture: RTL and testbench

//  Receive-side counterpart of the video output stage: accepts a DE/HS/VS/RGB pixel stream from an

---
 rtl/vid_in_capture_if.sv | 50 +++++
 rtl/vid_in_capture.sv | 212 +++++++++++++++++++++
 tb/tb_vid_in_capture.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_in_capture_if.sv
// Purpose: pixel-stream bundle between the video receiver pins, the capture block and its consumers.
// Latency: none, wires only.
// Backpressure: none; the stream is free-running and paced by pc_ena.
interface vid_in_capture_if #(
  parameter int RGB_hbit = 3,
  parameter int CNT_W    = 12
);
  // receiver side (pin polarity for the syncs)
  logic [3:0]        pc_ena;
  logic              vid_de_in;
  logic              hs_in;
  logic              vs_in;
  logic [RGB_hbit:0] r_in;
  logic [RGB_hbit:0] g_in;
  logic [RGB_hbit:0] b_in;

  // re-aligned stream and position
  logic [RGB_hbit:0] r_out;
  logic [RGB_hbit:0] g_out;
  logic [RGB_hbit:0] b_out;
  logic              hde_out;
  logic              vde_out;
  logic              hs_out;
  logic              vs_out;
  logic [CNT_W-1:0]  x_pos;
  logic [CNT_W-1:0]  y_pos;

  // timing status and measurements
  logic              frame_start;
  logic              locked;
  logic              unlock_pulse;
  logic [CNT_W-1:0]  h_total;
  logic [CNT_W-1:0]  h_active;
  logic [CNT_W-1:0]  v_total;
  logic [CNT_W-1:0]  v_active;

  // stream source / status consumer
  modport master (
    output pc_ena, vid_de_in, hs_in, vs_in, r_in, g_in, b_in,
    input  r_out, g_out, b_out, hde_out, vde_out, hs_out, vs_out, x_pos, y_pos,
    input  frame_start, locked, unlock_pulse, h_total, h_active, v_total, v_active
  );

  // capture block
  modport slave (
    input  pc_ena, vid_de_in, hs_in, vs_in, r_in, g_in, b_in,
    output r_out, g_out, b_out, hde_out, vde_out, hs_out, vs_out, x_pos, y_pos,
    output frame_start, locked, unlock_pulse, h_total, h_active, v_total, v_active
  );
endinterface

// File: rtl/vid_in_capture.sv
// Purpose: capture a DE/HS/VS/RGB stream, track x/y position, measure frame timing and declare lock.
// Latency: 1 pixel strobe from input pins to every stream/position output (all aligned).
// Backpressure: none; all state advances only on pixel strobes (pc_ena==0), there is no stall path.
module vid_in_capture #(
  parameter int RGB_hbit  = 3,
  parameter bit HS_invert = 1'b1,
  parameter bit VS_invert = 1'b1,
  parameter int CNT_W     = 12
) (
  input logic          pclk,
  input logic          reset,
  vid_in_capture_if.slave vif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  // Reset: asserted asynchronously, released two clocks later in step with pclk.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  // Reset synchronizer for clean release.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  // Sampled inputs in internal (active-high) polarity.
  logic strobe, hs_i, vs_i, de_i;
  assign strobe = (vif.pc_ena == 4'd0);
  assign hs_i   = vif.hs_in ^ HS_invert;
  assign vs_i   = vif.vs_in ^ VS_invert;
  assign de_i   = vif.vid_de_in;

  // Stream registers.
  logic              hs_q, vs_q, de_q, vde_q, fs_q;
  logic              vde_d;
  logic [RGB_hbit:0] r_q, g_q, b_q;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;

  // Timing counters and per-line measurements.
  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]  line_de_cnt_q, line_de_cnt_d;
  logic [CNT_W-1:0]  h_line_q, h_line_d;
  logic [CNT_W-1:0]  h_act_line_q, h_act_line_d;
  logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0]  v_act_cnt_q, v_act_cnt_d;
  logic [CNT_W-1:0]  v_line_cnt, v_act_line_cnt;

  // Published measurement set (also the lock reference).
  logic [CNT_W-1:0]  h_total_q, h_active_q, v_total_q, v_active_q;

  // Lock FSM.
  state_t            state_q;
  logic              ref_vld_q, locked_q, unlock_q;

  logic hs_rise, vs_rise, line_has_de, first_de, wdog_trip, meas_match;

  assign hs_rise = hs_i & ~hs_q;
  assign vs_rise = vs_i & ~vs_q;

  // Next-state for counters, position and the measurement set presented at vs rise.
  always_comb begin
    line_has_de    = (line_de_cnt_q != '0);
    h_cnt_d        = hs_rise ? '0 : sat_inc(h_cnt_q, 1'b1);
    // The pixel on the hs-rise strobe already belongs to the new line.
    line_de_cnt_d  = hs_rise ? {{(CNT_W-1){1'b0}}, de_i} : sat_inc(line_de_cnt_q, de_i);
    h_line_d       = hs_rise ? sat_inc(h_cnt_q, 1'b1) : h_line_q;
    // Blank lines carry no active width, so only lines with DE refresh h_active.
    h_act_line_d   = (hs_rise && line_has_de) ? line_de_cnt_q : h_act_line_q;
    // A line ending on the vs-rise strobe is counted into the finished frame.
    v_line_cnt     = sat_inc(v_cnt_q, hs_rise);
    v_act_line_cnt = sat_inc(v_act_cnt_q, hs_rise & line_has_de);
    v_cnt_d        = vs_rise ? '0 : v_line_cnt;
    v_act_cnt_d    = vs_rise ? '0 : v_act_line_cnt;

    x_d      = (de_i && de_q) ? sat_inc(x_q, 1'b1) : '0;
    first_de = de_i && (hs_rise || !line_has_de);
    y_d      = y_q;
    if (vs_rise)       y_d = '0;
    else if (first_de) y_d = vde_q ? sat_inc(y_q, 1'b1) : '0;
    vde_d    = vs_rise ? de_i : (vde_q | de_i);

    // Fires once, on the strobe h_cnt enters saturation.
    wdog_trip  = (h_cnt_d == CNT_MAX) && (h_cnt_q != CNT_MAX);
    meas_match = (h_line_d == h_total_q) && (h_act_line_d == h_active_q) &&
                 (v_line_cnt == v_total_q) && (v_act_line_cnt == v_active_q) &&
                 (h_line_d != '0) && (v_line_cnt != '0);
  end

  // Stream, position, counters and measurement registers, advanced per strobe.
  always_ff @(posedge pclk or posedge rst_int) begin
    if (rst_int) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      vde_q         <= 1'b0;
      fs_q          <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      h_cnt_q       <= '0;
      line_de_cnt_q <= '0;
      h_line_q      <= '0;
      h_act_line_q  <= '0;
      v_cnt_q       <= '0;
      v_act_cnt_q   <= '0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
    end else if (strobe) begin
      hs_q          <= hs_i;
      vs_q          <= vs_i;
      de_q          <= de_i;
      vde_q         <= vde_d;
      fs_q          <= vs_rise;
      r_q           <= de_i ? vif.r_in : '0;
      g_q           <= de_i ? vif.g_in : '0;
      b_q           <= de_i ? vif.b_in : '0;
      x_q           <= x_d;
      y_q           <= y_d;
      h_cnt_q       <= h_cnt_d;
      line_de_cnt_q <= line_de_cnt_d;
      h_line_q      <= h_line_d;
      h_act_line_q  <= h_act_line_d;
      v_cnt_q       <= v_cnt_d;
      v_act_cnt_q   <= v_act_cnt_d;
      if (vs_rise) begin
        h_total_q  <= h_line_d;
        h_active_q <= h_act_line_d;
        v_total_q  <= v_line_cnt;
        v_active_q <= v_act_line_cnt;
      end
    end
  end

  // Lock FSM: sync to a vs rise, compare consecutive frames, watchdog on lost hsync.
  always_ff @(posedge pclk or posedge rst_int) begin
    if (rst_int) begin
      state_q   <= SEARCH;
      ref_vld_q <= 1'b0;
      locked_q  <= 1'b0;
      unlock_q  <= 1'b0;
    end else if (strobe) begin
      unlock_q <= 1'b0;
      if (wdog_trip) begin
        state_q   <= SEARCH;
        ref_vld_q <= 1'b0;
        locked_q  <= 1'b0;
        unlock_q  <= (state_q == LOCKED);
      end else if (vs_rise) begin
        case (state_q)
          SEARCH: begin
            // The frame in flight was only partly seen; it never becomes a reference.
            state_q   <= MEASURE;
            ref_vld_q <= 1'b0;
          end
          MEASURE: begin
            if (ref_vld_q && meas_match) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              ref_vld_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (!meas_match) begin
              state_q   <= MEASURE;
              locked_q  <= 1'b0;
              unlock_q  <= 1'b1;
              ref_vld_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= SEARCH;
            ref_vld_q <= 1'b0;
            locked_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign vif.r_out        = r_q;
  assign vif.g_out        = g_q;
  assign vif.b_out        = b_q;
  assign vif.hde_out      = de_q;
  assign vif.vde_out      = vde_q;
  assign vif.hs_out       = hs_q;
  assign vif.vs_out       = vs_q;
  assign vif.x_pos        = x_q;
  assign vif.y_pos        = y_q;
  assign vif.frame_start  = fs_q;
  assign vif.locked       = locked_q;
  assign vif.unlock_pulse = unlock_q;
  assign vif.h_total      = h_total_q;
  assign vif.h_active     = h_active_q;
  assign vif.v_total      = v_total_q;
  assign vif.v_active     = v_active_q;

endmodule

// File: tb/tb_vid_in_capture.sv
// Purpose: directed frame stimulus with a geometry-based expectation model and per-cycle compare.
// Latency: expects every stream output one pixel strobe after its input.
// Backpressure: none; the bench paces pixels with pc_ena.
module tb_vid_in_capture;
  localparam int RGB_hbit = 3;
  localparam int CNT_W    = 12;
  localparam bit HS_INV   = 1'b1;
  localparam bit VS_INV   = 1'b1;

  logic pclk = 1'b0;
  logic reset;

  vid_in_capture_if #(.RGB_hbit(RGB_hbit), .CNT_W(CNT_W)) vif();

  vid_in_capture #(
    .RGB_hbit (RGB_hbit),
    .HS_invert(HS_INV),
    .VS_invert(VS_INV),
    .CNT_W    (CNT_W)
  ) dut (
    .pclk (pclk),
    .reset(reset),
    .vif  (vif)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit       chk_px, chk_pos, chk_lock, chk_meas;
    bit       hde, hs, vs, vde, fs;
    bit [3:0] r, g, b;
    int       x, y;
    bit       locked, unlock;
    int       ht, ha, vt, va;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  bit   cyc_mode = 1'b0;

  // Frame-level model state: what the last full frame looked like and what lock should be.
  bit m_synced, m_prev_vld, m_locked, m_meas_known, m_unlock_evt, m_prev_full;
  int m_ht, m_ha, m_vt, m_va;
  int p_ht, p_ha, p_vt, p_va;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: pops an expectation at each strobe and re-checks it on every edge.
  initial begin : cmp
    exp_t cur;
    bit   cur_vld;
    bit   stb;
    cur_vld = 1'b0;
    forever begin
      @(posedge pclk);
      stb = (vif.pc_ena == 4'd0);
      #1;
      if (stb && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        cur_vld = 1'b1;
      end
      if (!chk_en) cur_vld = 1'b0;
      if (cur_vld) begin
        if (cur.chk_px) begin
          check("hde_out", int'(vif.hde_out), int'(cur.hde));
          check("hs_out", int'(vif.hs_out), int'(cur.hs));
          check("vs_out", int'(vif.vs_out), int'(cur.vs));
          check("vde_out", int'(vif.vde_out), int'(cur.vde));
          check("frame_start", int'(vif.frame_start), int'(cur.fs));
          check("r_out", int'(vif.r_out), int'(cur.r));
          check("g_out", int'(vif.g_out), int'(cur.g));
          check("b_out", int'(vif.b_out), int'(cur.b));
        end
        if (cur.chk_pos) begin
          check("x_pos", int'(vif.x_pos), cur.x);
          check("y_pos", int'(vif.y_pos), cur.y);
        end
        if (cur.chk_lock) begin
          check("locked", int'(vif.locked), int'(cur.locked));
          check("unlock_pulse", int'(vif.unlock_pulse), int'(cur.unlock));
        end
        if (cur.chk_meas) begin
          check("h_total", int'(vif.h_total), cur.ht);
          check("h_active", int'(vif.h_active), cur.ha);
          check("v_total", int'(vif.v_total), cur.vt);
          check("v_active", int'(vif.v_active), cur.va);
        end
      end
    end
  end

  task automatic model_reset();
    m_synced     = 1'b0;
    m_prev_vld   = 1'b0;
    m_locked     = 1'b0;
    m_meas_known = 1'b0;
    m_unlock_evt = 1'b0;
    m_prev_full  = 1'b0;
  endtask

  // Lock rule at a vs rise: locked iff the finished frame equals the previous one.
  task automatic vs_event();
    bit lk;
    m_unlock_evt = 1'b0;
    if (!m_synced || !m_prev_full) begin
      m_synced     = 1'b1;
      m_prev_vld   = 1'b0;
      m_locked     = 1'b0;
      m_meas_known = 1'b0;
    end else begin
      lk = m_prev_vld && (p_ht == m_ht) && (p_ha == m_ha) && (p_vt == m_vt) &&
           (p_va == m_va) && (p_ht != 0) && (p_vt != 0);
      m_unlock_evt = m_locked && !lk;
      m_locked     = lk;
      m_prev_vld   = 1'b1;
      m_meas_known = 1'b1;
      m_ht = p_ht; m_ha = p_ha; m_vt = p_vt; m_va = p_va;
    end
  endtask

  // One pixel: drive pins (internal polarity given), queue its expectation, advance to the strobe.
  task automatic drive_pixel(input bit de, input bit hs, input bit vs,
                             input bit [3:0] r, input bit [3:0] g, input bit [3:0] b,
                             input exp_t e);
    vif.vid_de_in = de;
    vif.hs_in     = hs ^ HS_INV;
    vif.vs_in     = vs ^ VS_INV;
    vif.r_in      = r;
    vif.g_in      = g;
    vif.b_in      = b;
    exp_q.push_back(e);
    if (cyc_mode) begin
      for (int k = 1; k < 4; k++) begin
        vif.pc_ena = 4'(k);
        @(posedge pclk);
        #2;
      end
    end
    vif.pc_ena = 4'd0;
    @(posedge pclk);
    #2;
  endtask

  task automatic idle(input int n);
    exp_t e;
    e = '{default: 0};
    for (int i = 0; i < n; i++) drive_pixel(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, e);
  endtask

  // Frame: hs high px 0-1, vs high lines 0-1, DE on lines 1..vact at px 2..2+hact-1.
  task automatic gen_frame(input int htot, input int hact, input int vtot, input int vact,
                           input int max_px);
    exp_t e;
    int   cnt;
    bit   hs, vs, de;
    bit [3:0] r, g, b;
    cnt = 0;
    for (int l = 0; l < vtot; l++) begin
      for (int px = 0; px < htot; px++) begin
        if (max_px >= 0 && cnt >= max_px) begin
          m_prev_full = 1'b0;
          return;
        end
        cnt++;
        hs = (px < 2);
        vs = (l < 2);
        de = (l >= 1) && (l <= vact) && (px >= 2) && (px < 2 + hact);
        r  = 4'((px + l) & 15);
        g  = 4'(px & 15);
        b  = 4'((l + 5) & 15);
        if (l == 0 && px == 0) vs_event();
        e = '{default: 0};
        e.chk_px   = 1'b1;
        e.hde      = de;
        e.hs       = hs;
        e.vs       = vs;
        e.fs       = (l == 0 && px == 0);
        e.vde      = !((l == 0) || (l == 1 && px < 2));
        e.r        = de ? r : 4'd0;
        e.g        = de ? g : 4'd0;
        e.b        = de ? b : 4'd0;
        e.chk_pos  = de;
        e.x        = px - 2;
        e.y        = l - 1;
        e.chk_lock = 1'b1;
        e.locked   = m_locked;
        e.unlock   = (l == 0 && px == 0) && m_unlock_evt;
        e.chk_meas = m_meas_known;
        e.ht = m_ht; e.ha = m_ha; e.vt = m_vt; e.va = m_va;
        drive_pixel(de, hs, vs, r, g, b, e);
      end
    end
    p_ht = htot; p_ha = hact; p_vt = vtot; p_va = vact;
    m_prev_full = 1'b1;
  endtask

  task automatic good_frame();
    gen_frame(20, 16, 10, 8, -1);
  endtask

  initial begin : main
    int pulses;
    int first_at;
    vif.pc_ena    = 4'd0;
    vif.vid_de_in = 1'b0;
    vif.hs_in     = HS_INV;
    vif.vs_in     = VS_INV;
    vif.r_in      = 4'd9;
    vif.g_in      = 4'd9;
    vif.b_in      = 4'd9;
    reset = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    repeat (3) @(posedge pclk);
    #2;
    check("rst_locked", int'(vif.locked), 0);
    check("rst_unlock", int'(vif.unlock_pulse), 0);
    check("rst_h_total", int'(vif.h_total), 0);
    check("rst_v_total", int'(vif.v_total), 0);
    check("rst_x_pos", int'(vif.x_pos), 0);
    check("rst_r_out", int'(vif.r_out), 0);
    check("rst_hs_out", int'(vif.hs_out), 0);
    check("rst_vde_out", int'(vif.vde_out), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(4);

    // Lock on the third vs rise from reset.
    repeat (3) good_frame();
    check("t1_locked", int'(vif.locked), 1);
    check("t1_h_total", int'(vif.h_total), 20);
    check("t1_h_active", int'(vif.h_active), 16);
    check("t1_v_total", int'(vif.v_total), 10);
    check("t1_v_active", int'(vif.v_active), 8);

    // One narrow frame breaks lock; two good frames restore it.
    gen_frame(20, 15, 10, 8, -1);
    good_frame();
    check("t2_unlocked", int'(vif.locked), 0);
    good_frame();
    good_frame();
    check("t2_relocked", int'(vif.locked), 1);

    // Pixel phase cycling: outputs only move on pc_ena==0 strobes.
    cyc_mode = 1'b1;
    good_frame();
    cyc_mode = 1'b0;

    // Lost hsync: watchdog after h_cnt saturates (19 strobes already elapsed in last line).
    pulses   = 0;
    first_at = -1;
    for (int k = 1; k <= 4200; k++) begin
      idle(1);
      if (vif.unlock_pulse) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
    check("wdog_pulse_count", pulses, 1);
    check("wdog_pulse_strobe", first_at, 4076);
    check("wdog_locked", int'(vif.locked), 0);
    model_reset();
    good_frame();
    good_frame();
    check("wdog_search_no_early_lock", int'(vif.locked), 0);
    good_frame();
    check("wdog_relocked", int'(vif.locked), 1);

    // Reset mid-line while locked.
    gen_frame(20, 16, 10, 8, 75);
    check("t6_pre_locked", int'(vif.locked), 1);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_locked", int'(vif.locked), 0);
    check("t6_h_total", int'(vif.h_total), 0);
    check("t6_x_pos", int'(vif.x_pos), 0);
    check("t6_r_out", int'(vif.r_out), 0);
    check("t6_hde_out", int'(vif.hde_out), 0);
    check("t6_hs_out", int'(vif.hs_out), 0);
    repeat (2) @(posedge pclk);
    #2;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    idle(4);
    repeat (3) good_frame();
    check("t6_relocked", int'(vif.locked), 1);
    check("t6_v_active", int'(vif.v_active), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
